// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if: divider-monitor signal bundle; master drives div_in/err_clr, slave is the monitor.
interface div_clk_monitor_if #(parameter int CNT_W = 8);
  logic             div_in;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [15:0]      edge_cnt;
  modport master (output div_in, err_clr,
                  input  locked, err_pulse, err_sticky, high_len, low_len, edge_cnt);
  modport slave  (input  div_in, err_clr,
                  output locked, err_pulse, err_sticky, high_len, low_len, edge_cnt);
endinterface

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: samples a divided clock as data, measures high/low phases, reports lock and timing errors.
// Define DIV_MON_STICKY_EN to enable the latched err_sticky flag cleared by err_clr.
module div_clk_monitor #(
  parameter int HALF_PERIOD = 7,
  parameter int TOL         = 0,
  parameter int LOCK_PHASES = 4,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  div_clk_monitor_if.slave bus
);
  localparam int GW = $clog2(LOCK_PHASES + 1);
  localparam logic [CNT_W-1:0] LO = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(HALF_PERIOD + TOL);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  state_t           state, state_nx;
  logic             s1, s2, s_prev, toggle, good, stall, err_pulse, err_nx, err_sticky;
  logic [CNT_W-1:0] run_cnt, high_len, low_len;
  logic [GW-1:0]    good_cnt, good_nx;
  logic [15:0]      edge_cnt;
  assign toggle = s2 != s_prev;
  assign good   = run_cnt >= LO && run_cnt <= HI;
  // Stall fires as run_cnt steps onto HI+1; a coincident edge wins since toggle gates it.
  assign stall  = !toggle && state != IDLE && run_cnt == HI;
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_nx   = 1'b0;
    if (toggle) begin
      case (state)
        IDLE: begin
          state_nx = SYNC;
          good_nx  = '0;
        end
        SYNC: begin
          good_nx  = good ? good_cnt + 1'b1 : '0;
          err_nx   = !good;
          state_nx = (good && good_nx == GW'(LOCK_PHASES)) ? LOCKED : SYNC;
        end
        LOCKED: begin
          err_nx   = !good;
          state_nx = good ? LOCKED : SYNC;
          good_nx  = good ? good_cnt : '0;
        end
        default: state_nx = IDLE;
      endcase
    end else if (stall) begin
      err_nx   = 1'b1;
      state_nx = IDLE;
      good_nx  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s_prev    <= 1'b0;
      run_cnt   <= '0;
      high_len  <= '0;
      low_len   <= '0;
      edge_cnt  <= '0;
      good_cnt  <= '0;
      err_pulse <= 1'b0;
      state     <= IDLE;
    end else begin
      s1        <= bus.div_in;
      s2        <= s1;
      s_prev    <= s2;
      run_cnt   <= toggle ? CNT_W'(1) : (&run_cnt ? run_cnt : run_cnt + 1'b1);
      if (toggle && s_prev) high_len <= run_cnt;
      if (toggle && !s_prev) low_len <= run_cnt;
      if (toggle) edge_cnt <= edge_cnt + 1'b1;
      good_cnt  <= good_nx;
      err_pulse <= err_nx;
      state     <= state_nx;
    end
  end
`ifdef DIV_MON_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_sticky <= 1'b0;
    else     err_sticky <= err_nx | (err_sticky & ~bus.err_clr);
  end
`else
  logic unused_clr;
  assign unused_clr = bus.err_clr;
  assign err_sticky = 1'b0;
`endif
  assign bus.locked     = state == LOCKED;
  assign bus.err_pulse  = err_pulse;
  assign bus.err_sticky = err_sticky;
  assign bus.high_len   = high_len;
  assign bus.low_len    = low_len;
  assign bus.edge_cnt   = edge_cnt;
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: random/directed phase stimulus into TOL=0 and TOL=1 monitors, checked against a phase-level model.
module tb_div_clk_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_clk_monitor_if #(.CNT_W(8)) i0 ();
  div_clk_monitor_if #(.CNT_W(8)) i1 ();
  div_clk_monitor #(.TOL(0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  div_clk_monitor #(.TOL(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  typedef struct {
    int         mode;
    int         streak;
    int         last;
    logic [7:0] hl;
    logic [7:0] ll;
    logic [15:0] ec;
    logic       err;
    logic       sticky;
  } mdl_t;
  mdl_t m[2];
  int   tolv[2] = '{0, 1};
  logic h0, h1, h2, lvl;
  int   cyc = 0, checks = 0, errors = 0;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].mode = 0; m[i].streak = 0; m[i].last = cyc + 1;
      m[i].hl = 0; m[i].ll = 0; m[i].ec = 0; m[i].err = 0; m[i].sticky = 0;
    end
    h0 = 0; h1 = 0; h2 = 0;
  endtask
  // An input transition becomes visible two updates later; phase length is the gap between such updates.
  task automatic model_step(logic v, logic c);
    bit ev = h1 != h2;
    for (int i = 0; i < 2; i++) begin
      int  el = cyc - m[i].last;
      bit  ok;
      if (el > 255) el = 255;
      ok = el >= 7 - tolv[i] && el <= 7 + tolv[i];
      m[i].err = 0;
      if (ev) begin
        if (h2) m[i].hl = 8'(el); else m[i].ll = 8'(el);
        m[i].ec++;
        m[i].last = cyc;
        if (m[i].mode == 0) begin
          m[i].mode = 1; m[i].streak = 0;
        end else if (!ok) begin
          m[i].err = 1; m[i].mode = 1; m[i].streak = 0;
        end else if (m[i].mode == 1) begin
          m[i].streak++;
          if (m[i].streak == 4) m[i].mode = 2;
        end
      end else if (m[i].mode != 0 && el + 1 == 7 + tolv[i] + 1) begin
        m[i].err = 1; m[i].mode = 0; m[i].streak = 0;
      end
`ifdef DIV_MON_STICKY_EN
      m[i].sticky = m[i].err | (m[i].sticky & !c);
`else
      m[i].sticky = 0;
`endif
    end
    h2 = h1; h1 = h0; h0 = v;
  endtask
  task automatic compare_all();
    check("locked0", int'(i0.locked), int'(m[0].mode == 2));
    check("err0", int'(i0.err_pulse), int'(m[0].err));
    check("sticky0", int'(i0.err_sticky), int'(m[0].sticky));
    check("hlen0", int'(i0.high_len), int'(m[0].hl));
    check("llen0", int'(i0.low_len), int'(m[0].ll));
    check("ecnt0", int'(i0.edge_cnt), int'(m[0].ec));
    check("locked1", int'(i1.locked), int'(m[1].mode == 2));
    check("err1", int'(i1.err_pulse), int'(m[1].err));
    check("sticky1", int'(i1.err_sticky), int'(m[1].sticky));
    check("hlen1", int'(i1.high_len), int'(m[1].hl));
    check("llen1", int'(i1.low_len), int'(m[1].ll));
    check("ecnt1", int'(i1.edge_cnt), int'(m[1].ec));
  endtask
  task automatic tick(logic v, logic c);
    i0.div_in = v; i1.div_in = v; i0.err_clr = c; i1.err_clr = c;
    @(posedge clk);
    cyc++;
    model_step(v, c);
    #1 compare_all();
  endtask
  task automatic ph(int n);
    repeat (n) tick(lvl, 1'b0);
    lvl = !lvl;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask
  initial begin
    i0.div_in = 0; i1.div_in = 0; i0.err_clr = 0; i1.err_clr = 0;
    lvl = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;
    repeat (8) ph(7);
    check("lock_init", int'(i0.locked), 1);
    while (lvl != 1) ph(7);
    ph(5);
    repeat (10) ph(7);
    check("relock", int'(i0.locked), 1);
    repeat (20) tick(lvl, 1'b0);
    check("held_unlocked", int'(i0.locked), 0);
    lvl = !lvl;
    repeat (8) ph(7);
    repeat (12) begin ph(6); ph(8); end
    check("tol1_lock", int'(i1.locked), 1);
    repeat (8) ph(7);
    repeat (3) tick(lvl, 1'b0);
    pulse_rst();
    ph(4); ph(3);
    repeat (8) ph(7);
    for (int p = 0; p < 80; p++) begin
      int n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : $urandom_range(6, 8);
      repeat (n) tick(lvl, 1'(($urandom_range(0, 5) == 0)));
      lvl = !lvl;
      if (p == 40) pulse_rst();
    end
    repeat (10) ph(7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
